// File: rtl/sensor_sched.sv
// Sensor frame scheduler: latches acc/gyro/mag frames and offers them one at a time to the Kalman core.
// SENSOR_SCHED_OVR_CNT_EN enables the saturating per-sensor overrun counters.
module sensor_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        sched_en,
  input  logic        acc_ready,
  input  logic        gyro_ready,
  input  logic        mag_ready,
  input  logic [47:0] acc_data,
  input  logic [47:0] gyro_data,
  input  logic [47:0] mag_data,
  output logic        kf_valid,
  input  logic        kf_ready,
  output logic [1:0]  kf_src,
  output logic [47:0] kf_data,
  output logic        frame_done,
  output logic [7:0]  acc_ovr,
  output logic [7:0]  gyro_ovr,
  output logic [7:0]  mag_ovr
);

  typedef enum logic {ST_IDLE, ST_OFFER} state_t;

  state_t            r_state;
  logic [2:0][47:0]  r_slot;
  logic [2:0]        r_pend;
  logic [1:0]        r_rr;
  logic [2:0]        r_mask;

  logic [2:0][47:0]  w_din;
  logic [2:0]        w_cap;
  logic              w_grant;
  logic [1:0]        w_grant_idx;
  logic [2:0]        w_grant_oh;
  logic [47:0]       w_grant_data;
  logic              w_accept;
  logic [2:0]        w_mask_nxt;
  int unsigned       w_j;

  // Round-robin search begins one past the last granted source.
  always_comb begin
    w_cap       = {mag_ready, gyro_ready, acc_ready};
    w_din       = {mag_data, gyro_data, acc_data};
    w_grant     = 1'b0;
    w_grant_idx = '0;
    w_j         = 0;
    if (r_state == ST_IDLE && sched_en) begin
      for (int unsigned k = 0; k < 3; k++) begin
        w_j = (32'(r_rr) + k + 1) % 3;
        if (!w_grant && r_pend[w_j]) begin
          w_grant     = 1'b1;
          w_grant_idx = 2'(w_j);
        end
      end
    end
    w_grant_oh = w_grant ? (3'b001 << w_grant_idx) : '0;
    case (w_grant_idx)
      2'd0:    w_grant_data = r_slot[0];
      2'd1:    w_grant_data = r_slot[1];
      default: w_grant_data = r_slot[2];
    endcase
    w_accept   = (r_state == ST_OFFER) && kf_ready;
    w_mask_nxt = r_mask | (w_accept ? (3'b001 << (kf_src - 2'd1)) : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_slot     <= '0;
      r_pend     <= '0;
      r_rr       <= 2'd2;
      r_mask     <= '0;
      kf_valid   <= 1'b0;
      kf_src     <= '0;
      kf_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            kf_valid <= 1'b1;
            kf_src   <= w_grant_idx + 2'd1;
            kf_data  <= w_grant_data;
            r_rr     <= w_grant_idx;
            r_state  <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (kf_ready) begin
            kf_valid <= 1'b0;
            kf_src   <= '0;
            r_state  <= ST_IDLE;
            if (&w_mask_nxt) begin
              r_mask     <= '0;
              frame_done <= 1'b1;
            end else begin
              r_mask <= w_mask_nxt;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // A capture in the grant cycle re-arms the slot after the old contents were taken.
      r_pend <= (r_pend & ~w_grant_oh) | w_cap;
      for (int unsigned i = 0; i < 3; i++) begin
        if (w_cap[i]) r_slot[i] <= w_din[i];
      end
    end
  end

`ifdef SENSOR_SCHED_OVR_CNT_EN
  logic [2:0][7:0] r_ovr;
  logic [2:0]      w_ovr_hit;

  assign w_ovr_hit = w_cap & r_pend & ~w_grant_oh;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (w_ovr_hit[i] && r_ovr[i] != 8'hFF) r_ovr[i] <= r_ovr[i] + 8'd1;
      end
    end
  end

  assign acc_ovr  = r_ovr[0];
  assign gyro_ovr = r_ovr[1];
  assign mag_ovr  = r_ovr[2];
`else
  assign acc_ovr  = '0;
  assign gyro_ovr = '0;
  assign mag_ovr  = '0;
`endif

endmodule

// File: doc/sensor_sched.md
# sensor_sched

Arbitration and sequencing controller between the three I2C sensor data registers (accelerometer, gyroscope, magnetometer) and the Kalman filter update core. It latches each 48-bit sample frame when its ready strobe fires. It presents the pending frames one at a time to the filter through a valid/ready handshake, rotating priority between sensors. It also signals when a complete acc+gyro+mag set has been consumed.

## Interface
- No parameters. Frame width is fixed at 48 bits (six bytes).
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- sched_en  in  1  enable; when low, no new grants are made (captures continue)
- acc_ready, gyro_ready, mag_ready  in  1 each  single-cycle frame-complete strobes
- acc_data, gyro_data, mag_data  in  48 each  frame contents, valid in the strobe cycle
- kf_valid  out  1  frame offered to filter
- kf_ready  in  1  filter accepts the offered frame this cycle
- kf_src  out  2  source of offered frame: 1=acc, 2=gyro, 3=mag (0 when idle)
- kf_data  out  48  offered frame
- frame_done  out  1  one-cycle pulse: all three sources consumed since last pulse
- acc_ovr, gyro_ovr, mag_ovr  out  8 each  saturating overrun counters (see Configuration)

## Operation
- Each source has a 48-bit slot and a pending bit. On `x_ready`, slot <= `x_data` and pending <= 1.
- Overrun: `x_ready` while pending=1 and the slot is not granted that cycle. The slot is overwritten (newest wins) and `x_ovr` increments, saturating at 255.
- FSM states:
  - IDLE: if sched_en=1 and any pending, grant the round-robin winner. Copy its slot into kf_data and its code into kf_src, clear its pending bit, then go to OFFER.
  - OFFER: kf_valid=1; kf_src/kf_data held stable. On kf_ready=1, return to IDLE.
  - OFFER ignores sched_en; an offered frame is always completed.
- Grant and capture in the same cycle for the same source: the grant takes the old slot contents. The new data then loads the slot with pending=1, and no overrun is counted.
- Round-robin: the search starts at the source after the last granted (acc→gyro→mag→acc). The pointer updates only on grant.
- Epoch mask (3 bits): on each accept (OFFER and kf_ready), set the bit for kf_src. If the mask becomes 111, frame_done pulses next cycle and the mask clears in the same edge. Repeated frames from one source do not set extra bits.

## Timing
- Reset values: FSM=IDLE, all pending=0, slots=0, kf_valid=0, kf_src=0, kf_data=0, frame_done=0, counters=0, RR pointer=mag (so acc wins first), epoch mask=0.
- Latency: strobe in cycle N → pending visible N+1 → grant at N+1 edge → kf_valid=1 in N+2.
- Accept in cycle M → kf_valid=0 in M+1 (IDLE). Next grant at M+1 edge → kf_valid in M+2. Maximum throughput is one frame per 2 cycles.
- kf_valid never drops without kf_ready. kf_src/kf_data do not change while kf_valid=1.
- After an accept, kf_src returns to 0 in the IDLE cycle. kf_data holds its last value.
- rst mid-OFFER: next cycle kf_valid=0 and all state is at reset values; the offered frame is lost.
- Strobes coincident with rst are dropped.

## Configuration
- SENSOR_SCHED_OVR_CNT_EN defined: the three 8-bit saturating overrun counters are implemented as described.
- Not defined: the counters are omitted and acc_ovr/gyro_ovr/mag_ovr are tied to 0. Overwrite-on-overrun behaviour is unchanged.

## Test plan
- After rst, pulse acc_ready with data 0x0000_1111_2222, hold kf_ready=1 → kf_valid in cycle N+2 with kf_src=1 and kf_data=0x000011112222; kf_valid=0 the next cycle.
- Pulse all three strobes in one cycle, kf_ready=1 → offers in order acc, gyro, mag, spaced 2 cycles apart. frame_done pulses exactly once, one cycle after the mag accept.
- Two gyro strobes 3 cycles apart with sched_en=0 → kf_data carries the second value; gyro_ovr=1 (0 with the macro undefined). Raising sched_en gives exactly one gyro offer.
- Offer mag with kf_ready=0 for 10 cycles while mag_ready pulses with a new value → kf_data stays at the old value throughout. After the accept, a second mag offer carries the new value and mag_ovr=0.
- Pulse acc 300 times with no accepts (sched_en=0) → acc_ovr saturates at 255.
- Assert rst during OFFER → next cycle kf_valid=0, kf_src=0, pending all 0. The first strobe after reset is offered normally.
